// File: rtl/gru_param_loader.sv
// ---------------------------------------------------------------------------
// gru_param_loader
//
// Parameter-fill stage for the GRU update gate. It takes one stream of
// FLOAT_W-bit words and writes them in a fixed order into three parameter
// stores: N_BIAS biases, then N_IN_W input weights, then N_REC_W recurrent
// weights. Every accepted word is written one cycle later through a
// registered write port.
//
// Optional feature macro: GRU_PARAM_CHECKSUM_EN
//   When defined, one extra stream word follows the recurrent weights. It is
//   compared with the running XOR of all parameter words, and the result is
//   reported on chk_err. When undefined, chk_err is tied to 0.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous, active-high reset
//   start      in   one-cycle pulse that begins a full load (ignored while busy)
//   s_valid    in   stream word present
//   s_data     in   stream word
//   s_ready    out  a word is accepted this cycle if s_valid is high
//   wr_en      out  write strobe to the parameter stores
//   wr_sel     out  target store: 0 bias, 1 input weights, 2 recurrent weights
//   wr_addr    out  word index within the selected store
//   wr_data    out  word to write
//   busy       out  load in progress
//   done       out  load complete; held until the next accepted start or rst
//   chk_err    out  checksum mismatch (checksum build only, otherwise 0)
//   dbg_state  out  current FSM state encoding, for observation only
//
// Handshake: a word transfers on a rising edge where s_valid && s_ready.
// s_ready depends only on registered state and never on s_valid, so the
// upstream side may hold s_valid high without any combinational loop.
// ---------------------------------------------------------------------------
module gru_param_loader #(
    parameter int FLOAT_W = 32,
    parameter int N_BIAS  = 72,
    parameter int N_IN_W  = 1728,
    parameter int N_REC_W = 1728
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               s_valid,
    input  logic [FLOAT_W-1:0] s_data,
    output logic               s_ready,
    output logic               wr_en,
    output logic [1:0]         wr_sel,
    output logic [10:0]        wr_addr,
    output logic [FLOAT_W-1:0] wr_data,
    output logic               busy,
    output logic               done,
    output logic               chk_err,
    output logic [2:0]         dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BIAS  = 3'd1,
        S_IN_W  = 3'd2,
        S_REC_W = 3'd3,
`ifdef GRU_PARAM_CHECKSUM_EN
        S_CHECK = 3'd4,
`endif
        S_DONE  = 3'd5
    } state_t;

    localparam logic [10:0] LAST_BIAS = 11'(N_BIAS - 1);
    localparam logic [10:0] LAST_IN_W = 11'(N_IN_W - 1);
    localparam logic [10:0] LAST_REC  = 11'(N_REC_W - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [10:0]        r_addr;
    logic [10:0]        w_addr_nxt;

    logic               r_wr_en;
    logic [1:0]         r_wr_sel;
    logic [10:0]        r_wr_addr;
    logic [FLOAT_W-1:0] r_wr_data;

    logic               w_ready;
    logic               w_accept;
    logic               w_sec_wr;
    logic               w_load_start;
    logic [1:0]         w_sel;

    // Ready in every state that consumes stream words.
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            S_BIAS, S_IN_W, S_REC_W: w_ready = 1'b1;
`ifdef GRU_PARAM_CHECKSUM_EN
            S_CHECK:                 w_ready = 1'b1;
`endif
            default:                 w_ready = 1'b0;
        endcase
    end

    assign w_accept     = s_valid && w_ready;
    assign w_load_start = start && (r_state == S_IDLE || r_state == S_DONE);

    // Next state, address counter and section selector.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_sec_wr    = 1'b0;
        w_sel       = 2'd0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_BIAS;
                    w_addr_nxt  = 11'd0;
                end
            end
            S_BIAS: begin
                w_sel    = 2'd0;
                w_sec_wr = w_accept;
                if (w_accept) begin
                    if (r_addr == LAST_BIAS) begin
                        w_state_nxt = S_IN_W;
                        w_addr_nxt  = 11'd0;
                    end else begin
                        w_addr_nxt = r_addr + 11'd1;
                    end
                end
            end
            S_IN_W: begin
                w_sel    = 2'd1;
                w_sec_wr = w_accept;
                if (w_accept) begin
                    if (r_addr == LAST_IN_W) begin
                        w_state_nxt = S_REC_W;
                        w_addr_nxt  = 11'd0;
                    end else begin
                        w_addr_nxt = r_addr + 11'd1;
                    end
                end
            end
            S_REC_W: begin
                w_sel    = 2'd2;
                w_sec_wr = w_accept;
                if (w_accept) begin
                    if (r_addr == LAST_REC) begin
`ifdef GRU_PARAM_CHECKSUM_EN
                        w_state_nxt = S_CHECK;
`else
                        w_state_nxt = S_DONE;
`endif
                        w_addr_nxt  = 11'd0;
                    end else begin
                        w_addr_nxt = r_addr + 11'd1;
                    end
                end
            end
`ifdef GRU_PARAM_CHECKSUM_EN
            S_CHECK: begin
                // The checksum word is consumed but never written.
                if (w_accept) begin
                    w_state_nxt = S_DONE;
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
                w_addr_nxt  = 11'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_addr    <= 11'd0;
            r_wr_en   <= 1'b0;
            r_wr_sel  <= 2'd0;
            r_wr_addr <= 11'd0;
            r_wr_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_wr_en <= w_sec_wr;
            if (w_sec_wr) begin
                r_wr_sel  <= w_sel;
                r_wr_addr <= r_addr;
                r_wr_data <= s_data;
            end
        end
    end

`ifdef GRU_PARAM_CHECKSUM_EN
    logic [FLOAT_W-1:0] r_xor;
    logic               r_chk_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_xor     <= '0;
            r_chk_err <= 1'b0;
        end else if (w_load_start) begin
            r_xor     <= '0;
            r_chk_err <= 1'b0;
        end else begin
            if (w_sec_wr) begin
                r_xor <= r_xor ^ s_data;
            end
            // Latched on the CHECK word so it rises together with done.
            if (r_state == S_CHECK && w_accept) begin
                r_chk_err <= (s_data != r_xor);
            end
        end
    end

    assign chk_err = r_chk_err;
`else
    assign chk_err = 1'b0;
`endif

    assign s_ready   = w_ready;
    assign busy      = w_ready;
    assign done      = (r_state == S_DONE);
    assign wr_en     = r_wr_en;
    assign wr_sel    = r_wr_sel;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_gru_param_loader.sv
module tb_gru_param_loader;

  localparam int N_BIAS  = 72;
  localparam int N_IN_W  = 1728;
  localparam int N_REC_W = 1728;
  localparam int N_PARAM = N_BIAS + N_IN_W + N_REC_W;
`ifdef GRU_PARAM_CHECKSUM_EN
  localparam int N_STREAM = N_PARAM + 1;
`else
  localparam int N_STREAM = N_PARAM;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready, wr_en, busy, done, chk_err;
  logic [1:0]  wr_sel;
  logic [10:0] wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  gru_param_loader dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .chk_err(chk_err),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [44:0] exp_q[$];          // {sel, addr, data} of each expected write
  logic [31:0] words[N_STREAM];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: stream word k lands in the section containing k, at k minus
  // the section's starting index.
  function automatic logic [44:0] exp_write(input int k, input logic [31:0] d);
    logic [1:0] sel;
    int base;
    if (k < N_BIAS) begin sel = 2'd0; base = 0; end
    else if (k < N_BIAS + N_IN_W) begin sel = 2'd1; base = N_BIAS; end
    else begin sel = 2'd2; base = N_BIAS + N_IN_W; end
    return {sel, 11'(k - base), d};
  endfunction

  // Every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) check("spurious_wr", 64'(wr_en), 64'd0);
      else check("wr", 64'({wr_sel, wr_addr, wr_data}), 64'(exp_q.pop_front()));
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, 64'(s_ready), 0);
    check({tag, "_wr_en"},   64'(wr_en),   0);
    check({tag, "_wr_sel"},  64'(wr_sel),  0);
    check({tag, "_wr_addr"}, 64'(wr_addr), 0);
    check({tag, "_wr_data"}, 64'(wr_data), 0);
    check({tag, "_busy"},    64'(busy),    0);
    check({tag, "_done"},    64'(done),    0);
    check({tag, "_chk_err"}, 64'(chk_err), 0);
  endtask

  // ---------------- driver ----------------
  // gap_pct: chance of s_valid low per cycle; stray_at: stream index at which
  // a stray start is pulsed; abort_at: stream index at which rst is applied.
  task automatic run_load(input int gap_pct, input bit rand_data, input int stray_at,
                          input int abort_at, input bit bad_sum);
    logic [31:0] sum = '0;
    int k = 0;
    for (int i = 0; i < N_PARAM; i++) begin
      words[i] = rand_data ? $urandom : 32'(i);
      sum ^= words[i];
    end
`ifdef GRU_PARAM_CHECKSUM_EN
    words[N_PARAM] = sum ^ {31'd0, bad_sum};
`endif
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("start_busy",    64'(busy),    1);
    check("start_s_ready", 64'(s_ready), 1);
    check("start_done",    64'(done),    0);
    check("start_chk_err", 64'(chk_err), 0);
    while (k < N_STREAM) begin
      if (abort_at >= 0 && k == abort_at) begin
        s_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        check_reset_outputs("mid_rst");
        check("mid_rst_pending", 64'(exp_q.size()), 0);
        return;
      end
      s_valid = ($urandom_range(99) >= gap_pct);
      s_data  = words[k];
      start   = (k == stray_at);
      @(posedge clk);
      if (s_valid) begin
        if (k < N_PARAM) exp_q.push_back(exp_write(k, words[k]));
        k++;
      end
      #1;
    end
    s_valid = 1'b0; start = 1'b0;
    check("end_done",    64'(done),    1);
    check("end_busy",    64'(busy),    0);
    check("end_s_ready", 64'(s_ready), 0);
`ifdef GRU_PARAM_CHECKSUM_EN
    check("end_chk_err", 64'(chk_err), 64'(bad_sum));
`else
    check("end_chk_err", 64'(chk_err), 0);
`endif
    @(posedge clk); #1;
    check("end_pending", 64'(exp_q.size()), 0);
    check("done_held",   64'(done),          1);
  endtask

  // ---------------- sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    check_reset_outputs("reset");

    // Stray s_valid in IDLE: nothing accepted, nothing written.
    s_valid = 1'b1; s_data = 32'hdead_beef;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("idle_s_ready", 64'(s_ready), 0);
    end
    s_valid = 1'b0;

    run_load(0,  1'b0, -1, -1, 1'b0);            // full load, data = index
    run_load(30, 1'b1, 40, -1, 1'b1);            // reload from DONE, gaps, stray start
    run_load(30, 1'b1, -1, N_BIAS + 500, 1'b0);  // reset at input-weight address 500
    run_load(0,  1'b1, -1, -1, 1'b0);            // clean load after reset
    run_load(20, 1'b1, -1, -1, 1'b1);            // bad checksum word (macro build)
    run_load(10, 1'b1, -1, -1, 1'b0);            // reload clears chk_err

    repeat (3) @(posedge clk);
    #1;
    check("final_pending", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
